// File: rtl/imm_extend_pipe_pkg.sv
// Shared types for the immediate extender pipeline: extension modes and
// the skid-buffer occupancy states.
package imm_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_SHL  = 2'b10,
    EXT_ONES = 2'b11
  } imm_mode_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_t;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode-side and execute-side valid/ready bundle of the immediate extender.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 11
);
  import imm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  imm_mode_t        in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/imm_extend_pipe_skid_fifo2.sv
// Two-entry valid/ready skid buffer: head is always the entry on offer,
// tail only holds the second entry while the consumer stalls.
module skid_fifo2
  import imm_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  buf_state_t   state, state_next;
  logic [W-1:0] head, head_next;
  logic [W-1:0] tail, tail_next;
  logic         push, pop;

  assign push_ready = (state != BUF_FULL) && !rst;
  assign pop_valid  = (state != BUF_EMPTY);
  assign pop_data   = head;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BUF_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_next;
      head  <= head_next;
      tail  <= tail_next;
    end
  end

  // In ONE with push and pop together the new entry goes straight to head.
  always_comb begin
    state_next = state;
    head_next  = head;
    tail_next  = tail;
    case (state)
      BUF_EMPTY: begin
        if (push) begin
          head_next  = push_data;
          state_next = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_next = push_data;
        end else if (push) begin
          tail_next  = push_data;
          state_next = BUF_FULL;
        end else if (pop) begin
          state_next = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (pop) begin
          head_next  = tail;
          state_next = BUF_ONE;
        end
      end
      default: state_next = BUF_EMPTY;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: combinational zero/sign/shift/one-fill
// extension at push, buffered with its overflow flag in a 2-entry skid FIFO.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 11,
  parameter int SHAMT = 1
) (
  input logic                clk,
  input logic                rst,
  imm_extend_pipe_if.slave   bus
);

  generate
    if (IN_W < 1 || OUT_W < IN_W || SHAMT < 0 || SHAMT >= OUT_W) begin : g_bad_params
      $error("imm_extend_pipe: illegal parameters IN_W=%0d OUT_W=%0d SHAMT=%0d",
             IN_W, OUT_W, SHAMT);
    end
  endgenerate

  // LOW_MASK covers the raw immediate bits, TOP_MASK the top SHAMT+1 bits.
  localparam logic [OUT_W-1:0] LOW_MASK = {OUT_W{1'b1}} >> (OUT_W - IN_W);
  localparam logic [OUT_W-1:0] TOP_MASK = {OUT_W{1'b1}} >> (OUT_W - 1 - SHAMT);

  logic [OUT_W-1:0] zero_ext, ones_ext, sign_ext, shl_ext, top_bits;
  logic [OUT_W-1:0] ext_data;
  logic             ext_ovf;
  logic [OUT_W:0]   fifo_in, fifo_out;

  assign zero_ext = OUT_W'(bus.in_data);
  assign ones_ext = zero_ext | ~LOW_MASK;
  assign sign_ext = bus.in_data[IN_W-1] ? ones_ext : zero_ext;
  assign shl_ext  = sign_ext << SHAMT;
  assign top_bits = sign_ext >> (OUT_W - 1 - SHAMT);

  always_comb begin
    ext_data = '0;
    ext_ovf  = 1'b0;
    case (bus.in_mode)
      EXT_ZERO: ext_data = zero_ext;
      EXT_SIGN: ext_data = sign_ext;
      EXT_SHL: begin
        ext_data = shl_ext;
        ext_ovf  = (top_bits != '0) && (top_bits != TOP_MASK);
      end
      EXT_ONES: ext_data = ones_ext;
      default:  ext_data = '0;
    endcase
  end

  assign fifo_in = {ext_ovf, ext_data};

  skid_fifo2 #(
    .W(OUT_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_valid(bus.in_valid),
    .push_ready(bus.in_ready),
    .push_data (fifo_in),
    .pop_valid (bus.out_valid),
    .pop_ready (bus.out_ready),
    .pop_data  (fifo_out)
  );

  assign bus.out_ovf  = fifo_out[OUT_W];
  assign bus.out_data = fifo_out[OUT_W-1:0];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: default 4->11 instance plus a 4->4
// instance that exercises the shift-overflow flag.
module tb_imm_extend_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IN_W(4), .OUT_W(11)) bus ();
  imm_extend_pipe_if #(.IN_W(4), .OUT_W(4))  obus ();

  imm_extend_pipe #(.IN_W(4), .OUT_W(11), .SHAMT(1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  imm_extend_pipe #(.IN_W(4), .OUT_W(4), .SHAMT(1)) dut_ovf (
    .clk(clk), .rst(rst), .bus(obus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = EXT_ZERO; bus.out_ready = 1'b0;
    obus.in_valid = 1'b0; obus.in_data = '0; obus.in_mode = EXT_ZERO; obus.out_ready = 1'b1;
    step(); step();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 11'h000) begin errors++; $display("[TB] FAIL reset_out_data got %h expected 000", bus.out_data); end
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_ovf got %b expected 0", bus.out_ovf); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_modes();
    logic [3:0]  vin  [4] = '{4'b1001, 4'b1001, 4'b1001, 4'b0001};
    imm_mode_t   vmode[4] = '{EXT_SIGN, EXT_ZERO, EXT_SHL, EXT_ONES};
    logic [10:0] vexp [4] = '{11'h7F9, 11'h009, 11'h7F2, 11'h7F1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = vin[i]; bus.in_mode = vmode[i];
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mode%0d_valid got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.out_data !== vexp[i]) begin errors++; $display("[TB] FAIL mode%0d_data got %h expected %h", i, bus.out_data, vexp[i]); end
      checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL mode%0d_ovf got %b expected 0", i, bus.out_ovf); end
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mode%0d_drain got %b expected 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_mode = EXT_SIGN;
    for (int i = 1; i <= 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 4'(i);
      step();
      checks++; if (bus.out_data !== 11'(i)) begin errors++; $display("[TB] FAIL b2b%0d_data got %h expected %h", i, bus.out_data, 11'(i)); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b%0d_in_ready got %b expected 1", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_mode = EXT_SIGN;
    bus.in_valid = 1'b1; bus.in_data = 4'd1;
    step();
    bus.in_data = 4'd2;
    step();
    bus.in_data = 4'd3;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_in_ready got %b expected 0", bus.in_ready); end
    step(); step();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_held_in_ready got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_data !== 11'h001) begin errors++; $display("[TB] FAIL bp_head1 got %h expected 001", bus.out_data); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_data !== 11'h002) begin errors++; $display("[TB] FAIL bp_head2 got %h expected 002", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_reopen_in_ready got %b expected 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_data !== 11'h003) begin errors++; $display("[TB] FAIL bp_head3 got %h expected 003", bus.out_data); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid3 got %b expected 1", bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_stability();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 4'b1001; bus.in_mode = EXT_SHL;
    step();
    bus.in_data = 4'b0001; bus.in_mode = EXT_ZERO;
    for (int i = 0; i < 5; i++) begin
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_data !== 11'h7F2 || bus.out_ovf !== 1'b0 || bus.out_valid !== 1'b1)
        begin errors++; $display("[TB] FAIL stable%0d got %h/%b/%b expected 7f2/0/1", i, bus.out_data, bus.out_ovf, bus.out_valid); end
    end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_data !== 11'h001) begin errors++; $display("[TB] FAIL stable_second got %h expected 001", bus.out_data); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stable_drain got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    bus.in_mode = EXT_ONES;
    bus.in_valid = 1'b1; bus.in_data = 4'd5;
    step();
    bus.in_data = 4'd6;
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_full got %b expected 0", bus.in_ready); end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_valid got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 11'h000) begin errors++; $display("[TB] FAIL mid_out_data got %h expected 000", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_ready got %b expected 1", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_emit got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_overflow();
    logic [3:0] vin  [4] = '{4'b0100, 4'b1110, 4'b1001, 4'b1001};
    imm_mode_t  vmode[4] = '{EXT_SHL, EXT_SHL, EXT_SIGN, EXT_ONES};
    logic [3:0] vexp [4] = '{4'b1000, 4'b1100, 4'b1001, 4'b1001};
    logic       vovf [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    obus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      obus.in_valid = 1'b1; obus.in_data = vin[i]; obus.in_mode = vmode[i];
      step();
      obus.in_valid = 1'b0;
      checks++; if (obus.out_data !== vexp[i]) begin errors++; $display("[TB] FAIL ovf%0d_data got %b expected %b", i, obus.out_data, vexp[i]); end
      checks++; if (obus.out_ovf !== vovf[i]) begin errors++; $display("[TB] FAIL ovf%0d_flag got %b expected %b", i, obus.out_ovf, vovf[i]); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_stability();
    test_reset_midstream();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
